// File: rtl/mem_sched_pkg.sv
// mem_sched_pkg: shared types and constants for the memory scheduler
package mem_sched_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {SRC_PPU, SRC_CPU, SRC_LDR} src_t;
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_OVERRUN = 1;
  localparam logic [7:0] RD_FILL = 8'hFF;
endpackage

// File: rtl/mem_sched_fifo.sv
// mem_sched_fifo: 2-entry loader write buffer; full is a plain flop bit so it can drive ioctl_wait
module mem_sched_fifo #(
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic wp, rp, do_push, do_pop;
  logic [1:0] cnt;
  assign full = cnt[1];
  assign empty = cnt == 2'd0;
  assign rdata = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp <= !wp;
      end
      if (do_pop) rp <= !rp;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
endmodule

// File: rtl/mem_sched.sv
// mem_sched: arbitrates CPU, PPU and loader accesses onto one req/ack memory port
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W  = 22,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              downloading,
  input  logic              ldr_wr,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_data,
  output logic              ldr_wait,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  output logic              cpu_done,
  input  logic              ppu_rd,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic [7:0]        ppu_din,
  output logic              ppu_done,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic              ram_ack,
  input  logic [7:0]        ram_dout,
  output logic [1:0]        err
);
  state_t state;
  src_t cur, win;
  logic [3:0] wd;
  logic cpu_v, cpu_we, ppu_v;
  logic [ADDR_W-1:0] cpu_a, ppu_a, ldr_a;
  logic [7:0] cpu_d, ldr_d, rd;
  logic [ADDR_W+7:0] f_q;
  logic f_full, f_empty, f_pop, any, grant, fin, cpu_ld, ppu_ld, cpu_ovr, ppu_ovr;
  mem_sched_fifo #(.W(ADDR_W + 8)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (ldr_wr),
    .pop  (f_pop),
    .wdata({ldr_addr, ldr_data}),
    .rdata(f_q),
    .full (f_full),
    .empty(f_empty)
  );
  assign {ldr_a, ldr_d} = f_q;
  assign ldr_wait = f_full;
  assign cpu_ld = (cpu_rd || cpu_wr) && !downloading;
  assign ppu_ld = ppu_rd && !downloading;
  assign any = !f_empty || (!downloading && (cpu_v || ppu_v));
  assign win = downloading ? SRC_LDR : ppu_v ? SRC_PPU : cpu_v ? SRC_CPU : SRC_LDR;
  assign grant = state == IDLE && any;
  assign fin = state == BUSY && (ram_ack || wd == 4'(TIMEOUT));
  assign f_pop = fin && cur == SRC_LDR;
  assign rd = ram_ack ? ram_dout : RD_FILL;
  // a slot handed to the memory port this cycle is no longer pending, so reloading it is not an overrun
  assign cpu_ovr = cpu_ld && cpu_v && !(grant && win == SRC_CPU);
  assign ppu_ovr = ppu_ld && ppu_v && !(grant && win == SRC_PPU);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cur <= SRC_PPU;
      wd <= 4'd0;
      cpu_v <= 1'b0;
      cpu_we <= 1'b0;
      cpu_a <= '0;
      cpu_d <= 8'd0;
      ppu_v <= 1'b0;
      ppu_a <= '0;
      ram_req <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_din <= 8'd0;
      cpu_din <= 8'd0;
      ppu_din <= 8'd0;
      cpu_done <= 1'b0;
      ppu_done <= 1'b0;
      err <= 2'd0;
    end else begin
      cpu_done <= 1'b0;
      ppu_done <= 1'b0;
      if (cpu_ld) {cpu_v, cpu_we, cpu_a, cpu_d} <= {1'b1, cpu_wr, cpu_addr, cpu_dout};
      else if (grant && win == SRC_CPU) cpu_v <= 1'b0;
      if (ppu_ld) {ppu_v, ppu_a} <= {1'b1, ppu_addr};
      else if (grant && win == SRC_PPU) ppu_v <= 1'b0;
      if (cpu_ovr || ppu_ovr || (ldr_wr && f_full)) err[ERR_OVERRUN] <= 1'b1;
      case (state)
        IDLE: if (any) begin
          state <= BUSY;
          cur <= win;
          wd <= 4'd0;
          ram_req <= 1'b1;
          ram_we <= win == SRC_LDR || (win == SRC_CPU && cpu_we);
          ram_addr <= win == SRC_PPU ? ppu_a : win == SRC_CPU ? cpu_a : ldr_a;
          ram_din <= win == SRC_CPU ? cpu_d : ldr_d;
        end
        BUSY: if (fin) begin
          state <= IDLE;
          ram_req <= 1'b0;
          if (!ram_ack) err[ERR_TIMEOUT] <= 1'b1;
          if (cur == SRC_CPU) begin
            cpu_done <= 1'b1;
            if (!ram_we) cpu_din <= rd;
          end
          if (cur == SRC_PPU) begin
            ppu_done <= 1'b1;
            ppu_din <= rd;
          end
        end else wd <= wd + 4'd1;
      endcase
    end
endmodule

// File: tb/tb_mem_sched.sv
// tb_mem_sched: scoreboard bench for the memory scheduler with a delayed-ack memory responder
module tb_mem_sched;
  localparam int AW = 22;
  typedef struct {logic we; logic [AW-1:0] addr; logic [7:0] din;} txn_t;
  logic clk = 0, reset = 1, downloading = 0, ldr_wr = 0, cpu_rd = 0, cpu_wr = 0, ppu_rd = 0, ram_ack = 0;
  logic [AW-1:0] ldr_addr = '0, cpu_addr = '0, ppu_addr = '0;
  logic [7:0] ldr_data = 0, cpu_dout = 0, ram_dout = 0;
  logic ldr_wait, cpu_done, ppu_done, ram_req, ram_we;
  logic [7:0] cpu_din, ppu_din, ram_din;
  logic [AW-1:0] ram_addr;
  logic [1:0] err;
  txn_t exp_ram[$];
  logic [7:0] exp_cpu[$], exp_ppu[$];
  int n_chk = 0, n_fail = 0, cyc = 0, n_cdone = 0, n_pdone = 0, ack_dly = 0;
  bit ack_en = 1;

  mem_sched dut (
    .clk(clk), .reset(reset), .downloading(downloading),
    .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_data(ldr_data), .ldr_wait(ldr_wait),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_done(cpu_done),
    .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_din(ppu_din), .ppu_done(ppu_done),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_ack(ram_ack), .ram_dout(ram_dout), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mdata(logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h78;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(string p);
    chk({p, "_ctrl"}, {ldr_wait, cpu_done, ppu_done, ram_req, ram_we, err}, 0);
    chk({p, "_addr"}, ram_addr, 0);
    chk({p, "_data"}, {ram_din, cpu_din, ppu_din}, 0);
  endtask

  task automatic exp_txn(logic we, logic [AW-1:0] a, logic [7:0] d);
    txn_t t;
    t.we = we;
    t.addr = a;
    t.din = d;
    exp_ram.push_back(t);
  endtask

  task automatic cpu_op(bit wr, logic [AW-1:0] a, logic [7:0] d);
    @(negedge clk);
    cpu_rd = !wr;
    cpu_wr = wr;
    cpu_addr = a;
    cpu_dout = d;
    @(negedge clk);
    cpu_rd = 0;
    cpu_wr = 0;
  endtask

  task automatic ppu_op(logic [AW-1:0] a);
    @(negedge clk);
    ppu_rd = 1;
    ppu_addr = a;
    @(negedge clk);
    ppu_rd = 0;
  endtask

  task automatic drain(string tag, int max);
    int k = 0;
    while ((exp_ram.size() != 0 || exp_cpu.size() != 0 || exp_ppu.size() != 0 || ram_req) && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(tag, k < max, 1);
  endtask

  // memory model: acks ack_dly cycles after ram_req is first seen
  initial begin
    int w = 0;
    forever begin
      @(negedge clk);
      if (ram_ack) ram_ack = 0;
      else if (ram_req && ack_en) begin
        if (w >= ack_dly) begin
          ram_ack = 1;
          ram_dout = mdata(ram_addr);
          w = 0;
        end else w++;
      end else w = 0;
    end
  end

  initial begin
    bit req_q;
    txn_t e;
    req_q = 0;
    forever begin
      @(negedge clk);
      if (reset) req_q = 0;
      else begin
        if (ram_req && !req_q) begin
          if (exp_ram.size() == 0) chk("ram_extra_req", exp_ram.size(), 1);
          else begin
            e = exp_ram.pop_front();
            chk("ram_we", ram_we, e.we);
            chk("ram_addr", ram_addr, e.addr);
            if (e.we) chk("ram_din", ram_din, e.din);
          end
        end
        if (cpu_done) begin
          n_cdone++;
          if (exp_cpu.size() == 0) chk("cpu_extra_done", exp_cpu.size(), 1);
          else chk("cpu_din", cpu_din, exp_cpu.pop_front());
        end
        if (ppu_done) begin
          n_pdone++;
          if (exp_ppu.size() == 0) chk("ppu_extra_done", exp_ppu.size(), 1);
          else chk("ppu_din", ppu_din, exp_ppu.pop_front());
        end
        req_q = ram_req;
      end
    end
  end

  initial begin
    int t0, g, k, c0, p0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset = 0;

    ack_dly = 2;
    exp_txn(0, 22'h000123, 0);
    exp_cpu.push_back(8'h5A);
    @(negedge clk);
    t0 = cyc;
    cpu_rd = 1;
    cpu_addr = 22'h000123;
    @(negedge clk);
    cpu_rd = 0;
    k = 0;
    while (!cpu_done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("cpu_rd_latency", cyc - t0, 5);
    @(negedge clk);
    chk("cpu_done_pulse", cpu_done, 0);
    drain("cpu_rd_drain", 20);

    ack_dly = 0;
    c0 = n_cdone;
    p0 = n_pdone;
    exp_txn(0, 22'h200040, 0);
    exp_txn(1, 22'h000010, 8'h11);
    exp_ppu.push_back(8'h38);
    exp_cpu.push_back(8'h5A);
    @(negedge clk);
    cpu_wr = 1;
    cpu_addr = 22'h000010;
    cpu_dout = 8'h11;
    ppu_rd = 1;
    ppu_addr = 22'h200040;
    @(negedge clk);
    cpu_wr = 0;
    ppu_rd = 0;
    drain("sim_drain", 30);
    chk("sim_cpu_done_cnt", n_cdone - c0, 1);
    chk("sim_ppu_done_cnt", n_pdone - p0, 1);

    downloading = 1;
    ack_en = 0;
    c0 = n_cdone;
    exp_txn(1, 22'h000100, 8'hA0);
    exp_txn(1, 22'h000101, 8'hA1);
    @(negedge clk);
    ldr_wr = 1;
    ldr_addr = 22'h000100;
    ldr_data = 8'hA0;
    cpu_rd = 1;
    cpu_addr = 22'h000999;
    @(negedge clk);
    cpu_rd = 0;
    ldr_addr = 22'h000101;
    ldr_data = 8'hA1;
    @(negedge clk);
    chk("ldr_wait_full", ldr_wait, 1);
    chk("err_ovr_before_drop", err[1], 0);
    ldr_addr = 22'h000102;
    ldr_data = 8'hA2;
    @(negedge clk);
    ldr_wr = 0;
    chk("err_ovr_drop", err[1], 1);
    ack_en = 1;
    drain("ldr_drain", 30);
    repeat (3) @(negedge clk);
    chk("ldr_wait_clear", ldr_wait, 0);
    chk("ldr_no_timeout", err[0], 0);
    chk("ldr_no_cpu_done", n_cdone - c0, 0);
    downloading = 0;

    ack_en = 0;
    exp_txn(0, 22'h000456, 0);
    exp_cpu.push_back(8'hFF);
    cpu_op(0, 22'h000456, 0);
    k = 0;
    while (!ram_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    g = cyc;
    k = 0;
    while (ram_req && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("hang_exit_cycles", cyc - g, 16);
    chk("hang_err0", err[0], 1);
    ack_en = 1;
    exp_txn(0, 22'h000003, 0);
    exp_ppu.push_back(mdata(22'h000003));
    ppu_op(22'h000003);
    drain("hang_recover_drain", 30);
    chk("err_sticky", err, 3);

    ack_en = 0;
    exp_txn(0, 22'h000077, 0);
    exp_ppu.push_back(mdata(22'h000077));
    ppu_op(22'h000077);
    k = 0;
    while (!ram_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("mid_req_up", ram_req, 1);
    @(negedge clk);
    reset = 1;
    #1;
    chk_zero("mid_rst");
    exp_ram.delete();
    exp_ppu.delete();
    @(negedge clk);
    reset = 0;
    ack_en = 1;
    p0 = n_pdone;
    exp_txn(0, 22'h001234, 0);
    exp_ppu.push_back(8'h5E);
    ppu_op(22'h001234);
    drain("post_rst_drain", 30);
    chk("post_rst_ppu_done_cnt", n_pdone - p0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
